// File: rtl/seq_shift_unit_pkg.sv
// Shared mode and state codes for the multi-cycle shifter.
package seq_shift_unit_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/seq_shift_unit_if.sv
// Request/result handshake bundle between the producer/consumer and the shifter.
interface seq_shift_unit_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [1:0]         in_mode;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_carry;

    modport master (
        output in_valid, in_data, in_shamt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_carry
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_carry
    );
endinterface

// File: rtl/seq_shift_unit_step.sv
// One combinational shift step of 0..STEP bits; carry keeps its old value on a zero step.
module seq_shift_unit_step
    import seq_shift_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int AMT_W = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] d,
    input  logic [AMT_W-1:0] amt,
    input  mode_e            mode,
    input  logic             carry_in,
    output logic [WIDTH-1:0] q,
    output logic             carry_out
);
    int sh;
    int idx;

    always_comb begin
        q         = d;
        carry_out = carry_in;
        sh        = int'(amt);
        idx       = 0;
        case (mode)
            SHIFT_SLL: q = d << sh;
            SHIFT_SRL: q = d >> sh;
            SHIFT_SRA: q = $signed(d) >>> sh;
            SHIFT_ROR: q = (d >> sh) | (d << (WIDTH - sh));
            default:   q = d;
        endcase
        if (sh != 0) begin
            // last bit to leave the word: top side for SLL, bottom side otherwise
            idx = (mode == SHIFT_SLL) ? (WIDTH - sh) : (sh - 1);
            for (int i = 0; i < WIDTH; i++) begin
                if (i == idx) carry_out = d[i];
            end
        end
    end
endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle SLL/SRL/SRA/ROR shifter: STEP bits per cycle, one request in flight.
module seq_shift_unit
    import seq_shift_unit_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int STEP    = 4,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_shift_unit_if.slave  bus
);
    localparam int AMT_W = $clog2(STEP + 1);

    state_e             state_q, state_d;
    mode_e              mode_q;
    logic [WIDTH-1:0]   data_q, step_data;
    logic [SHAMT_W-1:0] rem_q;
    logic [AMT_W-1:0]   amt;
    logic               carry_q, step_carry;
    logic               accept, last_step;

    // rem_q < WIDTH always, so the narrowing casts below never lose bits
    always_comb begin
        last_step = int'(rem_q) <= STEP;
        amt       = last_step ? AMT_W'(rem_q) : AMT_W'(STEP);
    end

    seq_shift_unit_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .AMT_W (AMT_W)
    ) u_step (
        .d         (data_q),
        .amt       (amt),
        .mode      (mode_q),
        .carry_in  (carry_q),
        .q         (step_data),
        .carry_out (step_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = (bus.in_shamt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_step) state_d = ST_DONE;
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            rem_q   <= '0;
            mode_q  <= SHIFT_SLL;
            carry_q <= 1'b0;
        end else if (accept) begin
            data_q  <= bus.in_data;
            rem_q   <= bus.in_shamt;
            mode_q  <= mode_e'(bus.in_mode);
            carry_q <= 1'b0;
        end else if (state_q == ST_SHIFT) begin
            data_q  <= step_data;
            rem_q   <= rem_q - SHAMT_W'(amt);
            carry_q <= step_carry;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_carry = carry_q;
endmodule

// File: tb/tb_seq_shift_unit.sv
// Randomised and directed checks of seq_shift_unit against a word-level reference model.
module tb_seq_shift_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    seq_shift_unit_if #(.WIDTH(32)) bus ();

    seq_shift_unit #(.WIDTH(32), .STEP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: shifts on double-width words, carry taken from the bit just past the edge.
    function automatic void ref_model(input logic [31:0] d, input logic [4:0] sh,
                                      input logic [1:0] m, output logic [31:0] r,
                                      output logic c, output int lat);
        logic [63:0] w;
        logic [32:0] lo;
        lo = {d, 1'b0} >> sh;
        case (m)
            2'b00: begin w = {32'd0, d} << sh; r = w[31:0]; c = w[32]; end
            2'b01: begin r = d >> sh; c = lo[0]; end
            2'b10: begin w = {{32{d[31]}}, d} >> sh; r = w[31:0]; c = lo[0]; end
            default: begin w = {d, d} >> sh; r = w[31:0]; c = lo[0]; end
        endcase
        lat = (sh == 0) ? 0 : (int'(sh) + 3) / 4;
    endfunction

    // Runs one transaction and reports what was observed; callers compare.
    task automatic do_op(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] m,
                         input int hold, output int lat, output logic [31:0] od,
                         output logic oc, output bit busy_rdy, output bit hold_ok,
                         output bit rel_ok, output bit tmo);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_shamt = sh; bus.in_mode = m;
        bus.out_ready = (hold == 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0; busy_rdy = 1'b0; hold_ok = 1'b1;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) busy_rdy = 1'b1;
            bus.in_valid = 1'($urandom); bus.in_data = $urandom;
            bus.in_shamt = 5'($urandom); bus.in_mode = 2'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        tmo = !bus.out_valid;
        bus.in_valid = 1'b0;
        od = bus.out_data; oc = bus.out_carry;
        if (bus.in_ready) busy_rdy = 1'b1;
        for (int k = 0; k < hold; k++) begin
            bus.in_valid = 1'($urandom); bus.in_data = $urandom;
            bus.out_ready = 1'($urandom) & 1'b0;
            @(posedge clk); #1;
            if (!bus.out_valid || bus.out_data !== od || bus.out_carry !== oc || bus.in_ready)
                hold_ok = 1'b0;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        rel_ok = !bus.out_valid && bus.in_ready;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b1; bus.in_data = 32'hFFFF_FFFF; bus.in_shamt = 5'd3;
        bus.in_mode = 2'b00; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0 || bus.out_carry !== 1'b0 ||
            bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: valid=%b data=%h carry=%b ready=%b, want 0/0/0/1",
                     bus.out_valid, bus.out_data, bus.out_carry, bus.in_ready);
        end
        @(negedge clk); rst_n = 1'b1; bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_no_accept: valid=%b ready=%b, want 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_directed();
        logic [31:0] dv [6] = '{32'h0000_0001, 32'hFFFF_FFEC, 32'hFFFF_FFEC,
                                32'h8000_0000, 32'h1234_5678, 32'hC000_0000};
        logic [4:0]  sv [6] = '{5'd2, 5'd2, 5'd2, 5'd31, 5'd8, 5'd1};
        logic [1:0]  mv [6] = '{2'b00, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00};
        logic [31:0] xv [6] = '{32'h0000_0004, 32'hFFFF_FFFB, 32'h3FFF_FFFB,
                                32'h0000_0001, 32'h7812_3456, 32'h8000_0000};
        logic        cv [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int          lv [6] = '{1, 1, 1, 8, 2, 1};
        int lat; logic [31:0] od; logic oc; bit br, ho, ro, to;
        for (int i = 0; i < 6; i++) begin
            do_op(dv[i], sv[i], mv[i], 0, lat, od, oc, br, ho, ro, to);
            tests++;
            if (to || od !== xv[i] || oc !== cv[i] || lat != lv[i] || br || !ro) begin
                fails++;
                $display("FAIL directed_%0d: data=%h carry=%b lat=%0d busy_ready=%b rel=%b tmo=%b, want data=%h carry=%b lat=%0d",
                         i, od, oc, lat, br, ro, to, xv[i], cv[i], lv[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] od; logic oc; bit br, ho, ro, to;
        do_op(32'hDEAD_BEEF, 5'd0, 2'b00, 5, lat, od, oc, br, ho, ro, to);
        tests++;
        if (to || od !== 32'hDEAD_BEEF || oc !== 1'b0 || br) begin
            fails++;
            $display("FAIL hold_result: data=%h carry=%b busy_ready=%b tmo=%b, want deadbeef/0/0/0",
                     od, oc, br, to);
        end
        tests++;
        if (!ho) begin
            fails++;
            $display("FAIL hold_stable: held=%b, want 1", ho);
        end
        tests++;
        if (!ro) begin
            fails++;
            $display("FAIL hold_release: released=%b, want 1", ro);
        end
    endtask

    task automatic test_reset_mid_shift();
        int lat; logic [31:0] od; logic oc; bit br, ho, ro, to;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 32'h8000_0000; bus.in_shamt = 5'd31;
        bus.in_mode = 2'b01; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0 || bus.out_carry !== 1'b0 ||
            bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_abort: valid=%b data=%h carry=%b ready=%b, want 0/0/0/1",
                     bus.out_valid, bus.out_data, bus.out_carry, bus.in_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        do_op(32'h0000_0003, 5'd2, 2'b00, 0, lat, od, oc, br, ho, ro, to);
        tests++;
        if (to || od !== 32'h0000_000C || oc !== 1'b0 || lat != 1 || !ro) begin
            fails++;
            $display("FAIL after_reset: data=%h carry=%b lat=%0d rel=%b tmo=%b, want 0000000c/0/1/1/0",
                     od, oc, lat, ro, to);
        end
    endtask

    task automatic test_back_to_back();
        int lat, elat; logic [31:0] od, er, d; logic oc, ec; bit br, ho, ro, to;
        logic [4:0] sh; logic [1:0] m; int hold;
        for (int n = 0; n < 60; n++) begin
            d = $urandom; sh = 5'($urandom); m = 2'($urandom);
            if (n < 8) sh = 5'(n * 4 + (n % 4));
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            ref_model(d, sh, m, er, ec, elat);
            do_op(d, sh, m, hold, lat, od, oc, br, ho, ro, to);
            tests++;
            if (to || od !== er || oc !== ec || lat != elat || br || !ho || !ro) begin
                fails++;
                $display("FAIL random_%0d (d=%h sh=%0d m=%0d hold=%0d): data=%h carry=%b lat=%0d busy_ready=%b held=%b rel=%b tmo=%b, want data=%h carry=%b lat=%0d",
                         n, d, sh, m, hold, od, oc, lat, br, ho, ro, to, er, ec, elat);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_shamt = '0;
        bus.in_mode = 2'b00; bus.out_ready = 1'b1;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
